// File: rtl/boot_loader.sv
// Byte-stream bootloader: parses a LEN_LO/LEN_HI/payload/CHK frame, writes little-endian
// words into instruction memory and holds the core in reset until the checksum verifies.
module boot_loader #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_mem_w_enb,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_w_data,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHK    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_BITS;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word;
    logic [7:0]  r_sum;
    logic        r_rx_ready;
    logic        r_mem_w_enb;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_w_data;
    logic        r_core_rst;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic        w_acc;
    logic [15:0] w_len;
    logic        w_last_word;
    logic [31:0] w_word_addr;

    assign w_acc       = i_rx_valid & r_rx_ready;
    assign w_len       = {i_rx_data, r_len_lo};
    assign w_last_word = ((r_word_idx + 16'd1) == r_len);
    // Only the in-range index bits form the address, so the top word lands at (2^ADDR_BITS-1)*4.
    assign w_word_addr = {{(30 - ADDR_BITS){1'b0}}, r_word_idx[ADDR_BITS-1:0], 2'b00};

    // Next-state decode of the frame parser.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) w_next = S_LEN_LO;
                else         w_next = r_state;
            end
            S_LEN_LO: begin
                if (w_acc) w_next = S_LEN_HI;
                else       w_next = r_state;
            end
            S_LEN_HI: begin
                if (!w_acc)                          w_next = r_state;
                else if ({1'b0, w_len} > MAX_WORDS)  w_next = S_ERR;
                else if (w_len == 16'd0)             w_next = S_CHK;
                else                                 w_next = S_DATA;
            end
            S_DATA: begin
                if (w_acc && (r_byte_cnt == 2'd3) && w_last_word) w_next = S_CHK;
                else                                              w_next = r_state;
            end
            S_CHK: begin
                if (!w_acc)                 w_next = r_state;
                else if (i_rx_data == r_sum) w_next = S_DONE;
                else                        w_next = S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, datapath and registered status outputs; status is decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_idx   <= 16'd0;
            r_byte_cnt   <= 2'd0;
            r_word       <= 24'd0;
            r_sum        <= 8'd0;
            r_rx_ready   <= 1'b0;
            r_mem_w_enb  <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_w_data <= 32'd0;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_rx_ready  <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                           (w_next == S_DATA)   || (w_next == S_CHK);
            r_busy      <= (w_next == S_LEN_LO) || (w_next == S_LEN_HI) ||
                           (w_next == S_DATA)   || (w_next == S_CHK);
            r_core_rst  <= (w_next != S_DONE);
            r_done      <= (w_next == S_DONE);
            r_error     <= (w_next == S_ERR);
            r_mem_w_enb <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) r_sum <= 8'd0;
                end
                S_LEN_LO: begin
                    if (w_acc) r_len_lo <= i_rx_data;
                end
                S_LEN_HI: begin
                    if (w_acc) begin
                        r_len      <= w_len;
                        r_word_idx <= 16'd0;
                        r_byte_cnt <= 2'd0;
                        r_sum      <= 8'd0;
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_sum      <= r_sum + i_rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= i_rx_data;
                            2'd1: r_word[15:8]  <= i_rx_data;
                            2'd2: r_word[23:16] <= i_rx_data;
                            default: begin
                                r_mem_w_enb  <= 1'b1;
                                r_mem_w_data <= {i_rx_data, r_word};
                                r_mem_addr   <= w_word_addr;
                                r_word_idx   <= r_word_idx + 16'd1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_sum <= r_sum;
                end
            endcase
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_mem_w_enb  = r_mem_w_enb;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_w_data = r_mem_w_data;
    assign o_core_rst   = r_core_rst;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued as payload bytes are sent
// and popped by a write monitor; per-scenario tasks check the load outcome.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        o_mem_w_enb;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_w_data;
    logic        o_core_rst;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;
    logic [63:0] sb[$];
    logic [7:0]  pl[$];

    boot_loader #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .o_mem_w_enb(o_mem_w_enb),
        .o_mem_addr(o_mem_addr), .o_mem_w_data(o_mem_w_data), .o_core_rst(o_core_rst),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    task automatic monitor();
        logic [63:0] exp;
        forever begin
            @(negedge clk);
            if (o_mem_w_enb) begin
                n_writes++;
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                             o_mem_addr, o_mem_w_data);
                end else begin
                    exp = sb.pop_front();
                    if ({o_mem_addr, o_mem_w_data} !== exp) begin
                        n_err++;
                        $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                                 o_mem_addr, o_mem_w_data, exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  t;
        logic rdy;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        t   = 0;
        rdy = o_rx_ready;
        while (!rdy && t < 50) begin
            @(negedge clk);
            rdy = o_rx_ready;
            t++;
        end
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, required 1");
        end
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_gap(input int gap_max);
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Sends length, the payload held in pl, and chk; queues each expected word write.
    task automatic send_frame(input logic [15:0] n, input logic [7:0] chk,
                              input int gap_max, input bit pulse_start);
        logic [31:0] w;
        w = 32'd0;
        send_gap(gap_max);
        send_byte(n[7:0]);
        send_gap(gap_max);
        send_byte(n[15:8]);
        for (int i = 0; i < int'(n) * 4; i++) begin
            w[(i % 4) * 8 +: 8] = pl[i];
            if (i % 4 == 3) sb.push_back({32'(i / 4) * 32'd4, w});
            send_gap(gap_max);
            if (pulse_start && (i == 2 || i == 5)) i_start = 1'b1;
            send_byte(pl[i]);
            i_start = 1'b0;
        end
        send_gap(gap_max);
        send_byte(chk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_busy && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic load_frame1(input logic [7:0] chk);
        pl.delete();
        pl = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
        sb.delete();
    endtask

    task automatic run_frame1(input int gap_max, input bit pulse_start);
        int w0;
        load_frame1(8'h97);
        w0 = n_writes;
        do_start();
        send_frame(16'd2, 8'h97, gap_max, pulse_start);
        wait_idle();
        n_vec++;
        if ({o_done, o_error, o_core_rst, o_busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL frame1_result: got done/err/core_rst/busy=%b, required 1000",
                     {o_done, o_error, o_core_rst, o_busy});
        end
        n_vec++;
        if (n_writes - w0 != 2 || sb.size() != 0) begin
            n_err++;
            $display("FAIL frame1_writes: got %0d writes (%0d pending), required 2 (0 pending)",
                     n_writes - w0, sb.size());
        end
        n_vec++;
        if (o_mem_addr !== 32'h4 || o_mem_w_data !== 32'h00A00113) begin
            n_err++;
            $display("FAIL frame1_last_word: got addr=%h data=%h, required 4 00a00113",
                     o_mem_addr, o_mem_w_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({o_rx_ready, o_mem_w_enb, o_core_rst, o_busy, o_done, o_error} !== 6'b001000 ||
            o_mem_addr !== 32'd0 || o_mem_w_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_values: got rdy/wen/crst/busy/done/err=%b addr=%h data=%h, required 001000 0 0",
                     {o_rx_ready, o_mem_w_enb, o_core_rst, o_busy, o_done, o_error}, o_mem_addr, o_mem_w_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({o_rx_ready, o_core_rst, o_busy} !== 3'b010) begin
            n_err++;
            $display("FAIL idle_state: got rdy/crst/busy=%b, required 010", {o_rx_ready, o_core_rst, o_busy});
        end
    endtask

    task automatic test_basic();
        run_frame1(0, 1'b0);
    endtask

    task automatic test_bad_checksum();
        int w0;
        load_frame1(8'h98);
        w0 = n_writes;
        do_start();
        n_vec++;
        if ({o_busy, o_done, o_core_rst} !== 3'b101) begin
            n_err++;
            $display("FAIL restart_after_done: got busy/done/crst=%b, required 101", {o_busy, o_done, o_core_rst});
        end
        send_frame(16'd2, 8'h98, 0, 1'b0);
        wait_idle();
        n_vec++;
        if ({o_done, o_error, o_core_rst, o_busy} !== 4'b0110 || n_writes - w0 != 2) begin
            n_err++;
            $display("FAIL bad_chk: got done/err/crst/busy=%b writes=%0d, required 0110 writes=2",
                     {o_done, o_error, o_core_rst, o_busy}, n_writes - w0);
        end
        do_start();
        n_vec++;
        if ({o_busy, o_error, o_rx_ready} !== 3'b101) begin
            n_err++;
            $display("FAIL restart_after_err: got busy/err/rdy=%b, required 101", {o_busy, o_error, o_rx_ready});
        end
        pulse_reset();
    endtask

    task automatic test_oversize();
        int w0;
        logic [7:0] sum;
        sb.delete();
        w0 = n_writes;
        do_start();
        send_byte(8'h01);
        send_byte(8'h04);
        n_vec++;
        if ({o_error, o_done, o_busy, o_rx_ready, o_core_rst} !== 5'b10001) begin
            n_err++;
            $display("FAIL oversize_len: got err/done/busy/rdy/crst=%b, required 10001",
                     {o_error, o_done, o_busy, o_rx_ready, o_core_rst});
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (o_rx_ready !== 1'b0 || n_writes != w0) begin
            n_err++;
            $display("FAIL oversize_quiet: got rdy=%b writes=%0d, required 0 0", o_rx_ready, n_writes - w0);
        end
        pl.delete();
        sum = 8'd0;
        for (int i = 0; i < 4096; i++) begin
            pl.push_back(8'($urandom_range(255, 0)));
            sum = sum + pl[i];
        end
        w0 = n_writes;
        do_start();
        send_frame(16'd1024, sum, 0, 1'b0);
        wait_idle();
        n_vec++;
        if ({o_done, o_error, o_core_rst} !== 3'b100 || n_writes - w0 != 1024 || sb.size() != 0) begin
            n_err++;
            $display("FAIL max_len: got done/err/crst=%b writes=%0d, required 100 writes=1024",
                     {o_done, o_error, o_core_rst}, n_writes - w0);
        end
        n_vec++;
        if (o_mem_addr !== 32'h0000_0FFC) begin
            n_err++;
            $display("FAIL max_len_last_addr: got %h, required 00000ffc", o_mem_addr);
        end
    endtask

    task automatic test_empty();
        int w0;
        sb.delete();
        pl.delete();
        w0 = n_writes;
        do_start();
        send_frame(16'd0, 8'h00, 0, 1'b0);
        wait_idle();
        n_vec++;
        if ({o_done, o_error, o_core_rst} !== 3'b100 || n_writes != w0) begin
            n_err++;
            $display("FAIL empty_ok: got done/err/crst=%b writes=%0d, required 100 writes=0",
                     {o_done, o_error, o_core_rst}, n_writes - w0);
        end
        do_start();
        send_frame(16'd0, 8'h01, 0, 1'b0);
        wait_idle();
        n_vec++;
        if ({o_done, o_error, o_core_rst} !== 3'b011 || n_writes != w0) begin
            n_err++;
            $display("FAIL empty_bad_chk: got done/err/crst=%b writes=%0d, required 011 writes=0",
                     {o_done, o_error, o_core_rst}, n_writes - w0);
        end
    endtask

    task automatic test_flow_control();
        run_frame1(5, 1'b1);
        run_frame1(5, 1'b0);
        run_frame1(0, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        int w0;
        load_frame1(8'h97);
        w0 = n_writes;
        do_start();
        send_byte(8'h02);
        send_byte(8'h00);
        sb.push_back({32'h0, 32'h00500093});
        for (int i = 0; i < 5; i++) send_byte(pl[i]);
        n_vec++;
        if (n_writes - w0 != 1 || sb.size() != 0) begin
            n_err++;
            $display("FAIL mid_load_write: got %0d writes, required 1", n_writes - w0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({o_rx_ready, o_mem_w_enb, o_core_rst, o_busy, o_done, o_error} !== 6'b001000 ||
            o_mem_addr !== 32'd0 || o_mem_w_data !== 32'd0) begin
            n_err++;
            $display("FAIL mid_load_reset: got rdy/wen/crst/busy/done/err=%b addr=%h data=%h, required 001000 0 0",
                     {o_rx_ready, o_mem_w_enb, o_core_rst, o_busy, o_done, o_error}, o_mem_addr, o_mem_w_data);
        end
        rst = 1'b0;
        @(negedge clk);
        run_frame1(0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_bad_checksum();
        test_oversize();
        test_empty();
        test_flow_control();
        test_reset_mid_load();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
